// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: debounced pushbutton front end for an RS latch stage.
// Each button passes through a two-flop synchroniser and a debouncer.
// A small FSM then turns the debounced levels into single-cycle S/R
// pulses that are never both high, and it flags a conflict when both
// buttons are held at once. PULSE_CNT counts every pulse issued.
module sr_pulse_gen #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_W      = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             SET_BTN,
  input  logic             RST_BTN,
  output logic             S,
  output logic             R,
  output logic             CONFLICT,
  output logic [CNT_W-1:0] PULSE_CNT
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SET  = 2'd1;
  localparam logic [1:0] ST_RST  = 2'd2;
  localparam logic [1:0] ST_CONF = 2'd3;

  logic [1:0]      set_sync;
  logic [1:0]      rst_sync;
  logic [1:0]      sync_lvl;   // [0] = set, [1] = reset
  logic [1:0]      db;         // debounced levels, same channel order
  logic [DB_W-1:0] db_cnt [2];

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            s_nxt;
  logic            r_nxt;

  // Two-flop synchronisers bring both raw buttons into the clock domain
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      set_sync <= '0;
      rst_sync <= '0;
    end else begin
      set_sync <= {set_sync[0], SET_BTN};
      rst_sync <= {rst_sync[0], RST_BTN};
    end
  end

  assign sync_lvl = {rst_sync[1], set_sync[1]};

  // Debounce: db follows sync only after DB_CYCLES consecutive differing samples
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      db <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        db_cnt[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        if (sync_lvl[ch] != db[ch]) begin
          if (db_cnt[ch] == DB_LAST) begin
            db[ch]     <= sync_lvl[ch];
            db_cnt[ch] <= '0;
          end else begin
            db_cnt[ch] <= db_cnt[ch] + 1'b1;
          end
        end else begin
          db_cnt[ch] <= '0;
        end
      end
    end
  end

  // Next-state and pulse decode from the debounced button pair
  always_comb begin
    state_nxt = state;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    case (state)
      ST_IDLE, ST_SET, ST_RST: begin
        if (db[0] && db[1]) begin
          state_nxt = ST_CONF;
        end else if (db[0]) begin
          state_nxt = ST_SET;
          s_nxt     = (state != ST_SET);
        end else if (db[1]) begin
          state_nxt = ST_RST;
          r_nxt     = (state != ST_RST);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CONF: begin
        if (!db[0] && !db[1]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Register state, pulses, conflict flag and pulse counter together
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state     <= ST_IDLE;
      S         <= 1'b0;
      R         <= 1'b0;
      CONFLICT  <= 1'b0;
      PULSE_CNT <= '0;
    end else begin
      state     <= state_nxt;
      S         <= s_nxt;
      R         <= r_nxt;
      CONFLICT  <= (state_nxt == ST_CONF);
      PULSE_CNT <= PULSE_CNT + {{(CNT_W-1){1'b0}}, (s_nxt | r_nxt)};
    end
  end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: stimulus queues each expected pulse
// (kind, cycle, counter value); a negedge monitor pops and compares.
module tb_sr_pulse_gen;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       set_btn;
  logic       rst_btn;
  logic       s;
  logic       r;
  logic       conflict;
  logic [7:0] pulse_cnt;

  typedef struct {
    bit         is_r;
    int         at;
    logic [7:0] cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_cnt = '0;
  int         c;

  sr_pulse_gen #(.DB_CYCLES(4), .DB_W(8), .CNT_W(8)) dut (
    .CLK       (clk),
    .RESET_L   (reset_l),
    .SET_BTN   (set_btn),
    .RST_BTN   (rst_btn),
    .S         (s),
    .R         (r),
    .CONFLICT  (conflict),
    .PULSE_CNT (pulse_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input bit is_r, input int at);
    exp_t e;
    model_cnt = model_cnt + 8'd1;
    e.is_r = is_r;
    e.at   = at;
    e.cnt  = model_cnt;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every S/R pulse must match the head of the scoreboard queue
  always @(negedge clk) begin
    if (s && r) begin
      checks++;
      errors++;
      $display("FAIL s_r_both_high: got S=1 R=1 expected at most one (cycle %0d)", cyc);
    end else if (s || r) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got S=%0b R=%0b expected none (cycle %0d)", s, r, cyc);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind_is_r", {31'd0, r}, {31'd0, mon_e.is_r});
        check("pulse_cycle", cyc, mon_e.at);
        check("pulse_cnt", {24'd0, pulse_cnt}, {24'd0, mon_e.cnt});
      end
    end
  end

  initial begin
    reset_l = 1'b0;
    set_btn = 1'b0;
    rst_btn = 1'b0;

    // 1: reset held while buttons toggle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_btn = i[0];
      rst_btn = i[1];
      check("reset_outputs", {29'd0, s, r, conflict}, 32'd0);
      check("reset_cnt", {24'd0, pulse_cnt}, 32'd0);
    end
    @(negedge clk);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    reset_l = 1'b1;
    tick(3);

    // 2: clean set press then clean reset press
    c = cyc; set_btn = 1'b1; expect_pulse(1'b0, c + 7);
    tick(20);
    check("t2_conflict", {31'd0, conflict}, 32'd0);
    set_btn = 1'b0;
    tick(10);
    c = cyc; rst_btn = 1'b1; expect_pulse(1'b1, c + 7);
    tick(12);
    check("t2_cnt", {24'd0, pulse_cnt}, 32'd2);
    rst_btn = 1'b0;
    tick(10);

    // 3: bouncing set button, then stable high
    set_btn = 1'b1; tick(1);
    set_btn = 1'b0; tick(1);
    set_btn = 1'b1; tick(1);
    set_btn = 1'b0; tick(1);
    c = cyc; set_btn = 1'b1; expect_pulse(1'b0, c + 7);
    tick(15);
    set_btn = 1'b0;
    tick(10);
    check("t3_cnt", {24'd0, pulse_cnt}, 32'd3);

    // 4: conflict entry, partial release, full release
    c = cyc; set_btn = 1'b1; expect_pulse(1'b0, c + 7);
    tick(15);
    rst_btn = 1'b1;
    tick(10);
    check("t4_conflict_set", {31'd0, conflict}, 32'd1);
    set_btn = 1'b0;
    tick(10);
    check("t4_conflict_hold", {31'd0, conflict}, 32'd1);
    rst_btn = 1'b0;
    tick(4);
    check("t4_conflict_debouncing", {31'd0, conflict}, 32'd1);
    tick(6);
    check("t4_conflict_clear", {31'd0, conflict}, 32'd0);
    check("t4_cnt", {24'd0, pulse_cnt}, 32'd4);

    // 5: handover from set to reset on the same edge
    c = cyc; set_btn = 1'b1; expect_pulse(1'b0, c + 7);
    tick(15);
    c = cyc; set_btn = 1'b0; rst_btn = 1'b1; expect_pulse(1'b1, c + 7);
    tick(3);
    check("t5_conflict_early", {31'd0, conflict}, 32'd0);
    tick(7);
    check("t5_conflict_late", {31'd0, conflict}, 32'd0);
    tick(5);
    rst_btn = 1'b0;
    tick(10);
    check("t5_cnt", {24'd0, pulse_cnt}, 32'd6);

    // 6a: 252 pulses by alternating handovers; counter wraps 255 -> 0
    c = cyc; set_btn = 1'b1; expect_pulse(1'b0, c + 7);
    tick(8);
    for (int i = 0; i < 251; i++) begin
      c = cyc;
      set_btn = ~set_btn;
      rst_btn = ~rst_btn;
      expect_pulse(rst_btn, c + 7);
      tick(8);
    end
    set_btn = 1'b0;
    rst_btn = 1'b0;
    tick(10);
    check("t6_wrap_cnt", {24'd0, pulse_cnt}, 32'd2);

    // 6b: reset asserted mid-press with set held
    set_btn = 1'b1;
    tick(3);
    reset_l = 1'b0;
    model_cnt = '0;
    tick(3);
    check("t6_reset_outputs", {29'd0, s, r, conflict}, 32'd0);
    check("t6_reset_cnt", {24'd0, pulse_cnt}, 32'd0);
    c = cyc; reset_l = 1'b1; expect_pulse(1'b0, c + 7);
    tick(15);
    set_btn = 1'b0;
    tick(12);
    check("t6_final_cnt", {24'd0, pulse_cnt}, 32'd1);

    check("missing_pulses", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
